// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes and bit positions
// used by the coprocessor-0 block and the pipeline around it.
package cp0_pkg;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_SR       = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;
   localparam logic [4:0] CP0_PRID     = 5'd15;

   localparam logic [4:0] EC_INT  = 5'd0;
   localparam logic [4:0] EC_ADEL = 5'd4;
   localparam logic [4:0] EC_ADES = 5'd5;
   localparam logic [4:0] EC_SYS  = 5'd8;
   localparam logic [4:0] EC_OV   = 5'd12;

   localparam int SR_IE        = 0;
   localparam int SR_EXL       = 1;
   localparam int SR_IM_LO     = 8;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_IP_LO  = 8;
   localparam int CAUSE_TI     = 30;
   localparam int CAUSE_BD     = 31;

   // Only address-error exceptions carry a meaningful faulting address.
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EC_ADEL) || (code == EC_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, writable Compare and the sticky
// timer-interrupt flag that feeds Cause.TI / IP7.
module cp0_timer #(
   parameter int TIMER_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wr_data,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic [31:0] count_reg;
   logic [31:0] count_next;
   logic [31:0] compare_reg;
   logic        ti_reg;

   always_comb begin
      count_next = count_reg + 32'd1;
      if (TIMER_EN == 0)
         count_next = '0;
      else if (count_we)
         count_next = wr_data;
   end

   // The match uses the post-update Count, so a loaded value can fire at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg   <= '0;
         compare_reg <= '0;
         ti_reg      <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (compare_we)
            compare_reg <= wr_data;
         if (compare_we)
            ti_reg <= 1'b0;
         else if ((TIMER_EN != 0) && (count_next == compare_reg))
            ti_reg <= 1'b1;
      end
   end

   assign count   = count_reg;
   assign compare = compare_reg;
   assign ti      = ti_reg;

endmodule

// File: rtl/cp0_ext.sv
// Coprocessor 0 beside the MEM stage: SR/Cause/EPC/BadVAddr state, interrupt
// request generation, exception capture with delay-slot EPC correction, ERET.
module cp0_ext
   import cp0_pkg::*;
#(
   parameter int          NUM_HWINT = 5,
   parameter logic [31:0] PRID_VAL  = 32'h0001_8000,
   parameter int          TIMER_EN  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           rd_addr,
   input  logic [4:0]           wr_addr,
   input  logic [31:0]          wr_data,
   input  logic                 we,
   input  logic [31:0]          pc,
   input  logic                 in_delay_slot,
   input  logic                 exc_valid,
   input  logic [4:0]           exc_code,
   input  logic [31:0]          bad_vaddr,
   input  logic                 eret,
   input  logic [NUM_HWINT-1:0] hwint,
   output logic                 int_req,
   output logic                 exc_take,
   output logic [31:0]          epc,
   output logic [31:0]          dout,
   output logic                 timer_int
);

   logic [7:0]           sr_im_reg;
   logic                 sr_exl_reg;
   logic                 sr_ie_reg;
   logic                 cause_bd_reg;
   logic [1:0]           cause_sw_reg;
   logic [4:0]           cause_exc_reg;
   logic [NUM_HWINT-1:0] hw_reg;
   logic [31:0]          epc_reg;
   logic [31:0]          badvaddr_reg;

   logic [7:0]  ip;
   logic        take;
   logic        wr_ok;
   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   assign ip[1:0] = cause_sw_reg;
   assign ip[7]   = ti;

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_hwip
         if (gi < NUM_HWINT) begin : g_used
            assign ip[2+gi] = hw_reg[gi];
         end else begin : g_unused
            assign ip[2+gi] = 1'b0;
         end
      end
   endgenerate

   // A synchronous exception always pre-empts a pending interrupt.
   assign int_req  = sr_ie_reg & ~sr_exl_reg & (|(ip & sr_im_reg)) & ~exc_valid;
   assign take     = exc_valid | int_req;
   assign exc_take = take;
   assign wr_ok    = we & ~take;

   cp0_timer #(
      .TIMER_EN (TIMER_EN)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (wr_ok && (wr_addr == CP0_COUNT)),
      .compare_we (wr_ok && (wr_addr == CP0_COMPARE)),
      .wr_data    (wr_data),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_im_reg     <= '0;
         sr_exl_reg    <= 1'b0;
         sr_ie_reg     <= 1'b0;
         cause_bd_reg  <= 1'b0;
         cause_sw_reg  <= '0;
         cause_exc_reg <= '0;
         hw_reg        <= '0;
         epc_reg       <= '0;
         badvaddr_reg  <= '0;
      end else begin
         hw_reg <= hwint;
         if (take) begin
            cause_exc_reg <= exc_valid ? exc_code : EC_INT;
            // Nested exceptions keep the original return point.
            if (!sr_exl_reg) begin
               epc_reg      <= in_delay_slot ? (pc - 32'd4) : pc;
               cause_bd_reg <= in_delay_slot;
            end
            sr_exl_reg <= 1'b1;
            if (exc_valid && is_addr_exc(exc_code))
               badvaddr_reg <= bad_vaddr;
         end else begin
            if (wr_ok && (wr_addr == CP0_SR)) begin
               sr_im_reg  <= wr_data[SR_IM_LO +: 8];
               sr_exl_reg <= wr_data[SR_EXL];
               sr_ie_reg  <= wr_data[SR_IE];
            end else if (eret) begin
               sr_exl_reg <= 1'b0;
            end
            if (wr_ok && (wr_addr == CP0_CAUSE))
               cause_sw_reg <= wr_data[CAUSE_IP_LO +: 2];
            if (wr_ok && (wr_addr == CP0_EPC))
               epc_reg <= wr_data;
         end
      end
   end

   assign sr_val    = {16'b0, sr_im_reg, 6'b0, sr_exl_reg, sr_ie_reg};
   assign cause_val = {cause_bd_reg, ti, 14'b0, ip, 1'b0, cause_exc_reg, 2'b0};

   always_comb begin
      dout = '0;
      case (rd_addr)
         CP0_BADVADDR: dout = badvaddr_reg;
         CP0_COUNT:    dout = count;
         CP0_COMPARE:  dout = compare;
         CP0_SR:       dout = sr_val;
         CP0_CAUSE:    dout = cause_val;
         CP0_EPC:      dout = epc_reg;
         CP0_PRID:     dout = PRID_VAL;
         default:      dout = '0;
      endcase
   end

   assign epc       = epc_reg;
   assign timer_int = ti;

endmodule

// File: tb/tb_cp0_ext.sv
// Directed bench for cp0_ext: expectations are queued as stimulus is applied
// and drained against the DUT outputs half a cycle after each edge.
module tb_cp0_ext;
   import cp0_pkg::*;

   localparam int K_REG  = 0;
   localparam int K_INT  = 1;
   localparam int K_TAKE = 2;
   localparam int K_TI   = 3;
   localparam int K_EPC  = 4;

   typedef struct {
      string       tag;
      int          kind;
      logic [4:0]  addr;
      logic [31:0] exp;
   } chk_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rd_addr = '0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        we = 1'b0;
   logic [31:0] pc = '0;
   logic        in_delay_slot = 1'b0;
   logic        exc_valid = 1'b0;
   logic [4:0]  exc_code = '0;
   logic [31:0] bad_vaddr = '0;
   logic        eret = 1'b0;
   logic [4:0]  hwint = '0;
   logic        int_req;
   logic        exc_take;
   logic [31:0] epc;
   logic [31:0] dout;
   logic        timer_int;

   chk_t sbq[$];
   int   checks = 0;
   int   failures = 0;

   cp0_ext dut (
      .clk           (clk),
      .rst           (rst),
      .rd_addr       (rd_addr),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .we            (we),
      .pc            (pc),
      .in_delay_slot (in_delay_slot),
      .exc_valid     (exc_valid),
      .exc_code      (exc_code),
      .bad_vaddr     (bad_vaddr),
      .eret          (eret),
      .hwint         (hwint),
      .int_req       (int_req),
      .exc_take      (exc_take),
      .epc           (epc),
      .dout          (dout),
      .timer_int     (timer_int)
   );

   always #100 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic exp_reg(input string tag, input logic [4:0] a, input logic [31:0] v);
      chk_t c;
      c.tag = tag; c.kind = K_REG; c.addr = a; c.exp = v;
      sbq.push_back(c);
   endtask

   task automatic exp_sig(input string tag, input int k, input logic [31:0] v);
      chk_t c;
      c.tag = tag; c.kind = k; c.addr = '0; c.exp = v;
      sbq.push_back(c);
   endtask

   task automatic drain();
      chk_t        c;
      logic [31:0] obs;
      while (sbq.size() > 0) begin
         c = sbq.pop_front();
         if (c.kind == K_REG) rd_addr = c.addr;
         #1;
         case (c.kind)
            K_REG:   obs = dout;
            K_INT:   obs = {31'b0, int_req};
            K_TAKE:  obs = {31'b0, exc_take};
            K_TI:    obs = {31'b0, timer_int};
            default: obs = epc;
         endcase
         checks++;
         assert (obs === c.exp)
         else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", c.tag, obs, c.exp);
         end
      end
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      wr_addr = a; wr_data = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic do_eret();
      eret = 1'b1;
      tick();
      eret = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      // reset state
      exp_reg("rst_sr", CP0_SR, 32'h0);
      exp_reg("rst_cause", CP0_CAUSE, 32'h0);
      exp_reg("rst_epc", CP0_EPC, 32'h0);
      exp_reg("rst_bva", CP0_BADVADDR, 32'h0);
      exp_reg("rst_count", CP0_COUNT, 32'h0);
      exp_reg("rst_compare", CP0_COMPARE, 32'h0);
      exp_reg("prid", CP0_PRID, 32'h0001_8000);
      exp_reg("unmapped", 5'd3, 32'h0);
      exp_sig("rst_int", K_INT, 32'h0);
      exp_sig("rst_take", K_TAKE, 32'h0);
      exp_sig("rst_ti", K_TI, 32'h0);
      drain();

      // hardware interrupt, one-cycle registration latency
      mtc0(CP0_SR, 32'h0000_0401);
      hwint = 5'b00001;
      exp_sig("hw_int_lat", K_INT, 32'h0);
      drain();
      tick();
      exp_sig("hw_int_req", K_INT, 32'h1);
      exp_sig("hw_take", K_TAKE, 32'h1);
      drain();
      pc = 32'h0000_1000;
      tick();
      exp_reg("hw_cause", CP0_CAUSE, 32'h0000_0400);
      exp_reg("hw_epc", CP0_EPC, 32'h0000_1000);
      exp_reg("hw_sr_exl", CP0_SR, 32'h0000_0403);
      exp_sig("hw_int_off", K_INT, 32'h0);
      exp_sig("hw_epc_out", K_EPC, 32'h0000_1000);
      drain();

      // delay-slot interrupt
      do_eret();
      pc = 32'h0000_3010; in_delay_slot = 1'b1;
      exp_sig("bd_int_req", K_INT, 32'h1);
      drain();
      tick();
      in_delay_slot = 1'b0; hwint = 5'b00000;
      exp_reg("bd_epc", CP0_EPC, 32'h0000_300C);
      exp_reg("bd_cause", CP0_CAUSE, 32'h8000_0400);
      drain();
      do_eret();
      exp_reg("bd_eret_sr", CP0_SR, 32'h0000_0401);
      exp_sig("bd_eret_int", K_INT, 32'h0);
      drain();

      // timer interrupt
      mtc0(CP0_COMPARE, 32'd10);
      mtc0(CP0_COUNT, 32'd0);
      mtc0(CP0_SR, 32'h0000_8001);
      for (int i = 0; i < 8; i++) tick();
      exp_reg("tmr_count9", CP0_COUNT, 32'd9);
      exp_sig("tmr_ti_pre", K_TI, 32'h0);
      exp_sig("tmr_int_pre", K_INT, 32'h0);
      drain();
      pc = 32'h0000_4000;
      tick();
      exp_reg("tmr_count10", CP0_COUNT, 32'd10);
      exp_sig("tmr_ti", K_TI, 32'h1);
      exp_sig("tmr_int", K_INT, 32'h1);
      exp_reg("tmr_cause", CP0_CAUSE, 32'hC000_8000);
      drain();
      tick();
      exp_reg("tmr_take_epc", CP0_EPC, 32'h0000_4000);
      exp_reg("tmr_take_cause", CP0_CAUSE, 32'h4000_8000);
      drain();
      mtc0(CP0_COMPARE, 32'd100);
      exp_sig("cmp_clr_ti", K_TI, 32'h0);
      exp_reg("cmp_val", CP0_COMPARE, 32'd100);
      drain();
      mtc0(CP0_COUNT, 32'd99);
      mtc0(CP0_COMPARE, 32'd200);
      exp_sig("cmp_wins", K_TI, 32'h0);
      exp_reg("cmp_count", CP0_COUNT, 32'd100);
      drain();

      // address-error exception while an interrupt is pending
      hwint = 5'b00001;
      mtc0(CP0_SR, 32'h0000_8403);
      do_eret();
      exp_sig("ade_int_pend", K_INT, 32'h1);
      drain();
      exc_valid = 1'b1; exc_code = EC_ADEL; bad_vaddr = 32'h0000_1002; pc = 32'h0000_2000;
      exp_sig("ade_int_mask", K_INT, 32'h0);
      exp_sig("ade_take", K_TAKE, 32'h1);
      drain();
      tick();
      exc_valid = 1'b0;
      exp_reg("ade_cause", CP0_CAUSE, 32'h0000_0410);
      exp_reg("ade_bva", CP0_BADVADDR, 32'h0000_1002);
      exp_reg("ade_epc", CP0_EPC, 32'h0000_2000);
      drain();

      // nested exception keeps EPC; overflow does not touch BadVAddr
      exc_valid = 1'b1; exc_code = EC_OV; bad_vaddr = 32'h0000_DEAD; pc = 32'h0000_5000;
      tick();
      exc_valid = 1'b0;
      exp_reg("nest_epc", CP0_EPC, 32'h0000_2000);
      exp_reg("nest_cause", CP0_CAUSE, 32'h0000_0430);
      exp_reg("nest_bva", CP0_BADVADDR, 32'h0000_1002);
      drain();
      hwint = 5'b00000;
      do_eret();
      exp_reg("nest_eret_sr", CP0_SR, 32'h0000_8401);
      drain();

      // Count wrap, then Count write together with ERET
      mtc0(CP0_COUNT, 32'hFFFF_FFFF);
      exp_reg("wrap_max", CP0_COUNT, 32'hFFFF_FFFF);
      drain();
      tick();
      exp_reg("wrap_zero", CP0_COUNT, 32'h0);
      drain();
      mtc0(CP0_SR, 32'h0000_0002);
      eret = 1'b1;
      mtc0(CP0_COUNT, 32'h0000_1234);
      eret = 1'b0;
      exp_reg("cw_eret_count", CP0_COUNT, 32'h0000_1234);
      exp_reg("cw_eret_sr", CP0_SR, 32'h0);
      drain();

      // a take drops a concurrent MTC0
      exc_valid = 1'b1; exc_code = EC_SYS; pc = 32'h0000_6000;
      mtc0(CP0_EPC, 32'h0000_AAAA);
      exc_valid = 1'b0;
      exp_reg("drop_epc", CP0_EPC, 32'h0000_6000);
      exp_reg("drop_sr", CP0_SR, 32'h0000_0002);
      exp_reg("sys_cause", CP0_CAUSE, 32'h0000_0020);
      drain();
      mtc0(CP0_EPC, 32'h0000_7777);
      mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
      mtc0(CP0_PRID, 32'h0);
      mtc0(CP0_BADVADDR, 32'h0000_5555);
      exp_sig("epc_wr", K_EPC, 32'h0000_7777);
      exp_reg("cause_sw_only", CP0_CAUSE, 32'h0000_0320);
      exp_reg("prid_ro", CP0_PRID, 32'h0001_8000);
      exp_reg("bva_ro", CP0_BADVADDR, 32'h0000_1002);
      drain();
      mtc0(CP0_SR, 32'h0000_0101);
      exp_sig("sw_int", K_INT, 32'h1);
      drain();

      // asynchronous reset mid-operation
      rst = 1'b1;
      exp_reg("mrst_sr", CP0_SR, 32'h0);
      exp_reg("mrst_cause", CP0_CAUSE, 32'h0);
      exp_reg("mrst_epc", CP0_EPC, 32'h0);
      exp_reg("mrst_bva", CP0_BADVADDR, 32'h0);
      exp_reg("mrst_count", CP0_COUNT, 32'h0);
      exp_sig("mrst_int", K_INT, 32'h0);
      drain();
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
